// File: rtl/burst_mem_pkg.sv
// Shared types and defaults for the burst memory responder.
package burst_mem_pkg;

  // Responder FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RLAT  = 3'd1,
    RDATA = 3'd2,
    WDATA = 3'd3,
    WRESP = 3'd4
  } state_e;

  // Byte-offset bits below the word index in a request address
  localparam int unsigned WORD_OFFSET_BITS = 2;

  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_NUM_WORDS       = 128;
  localparam int unsigned DEF_READ_BURST_LEN  = 8;
  localparam int unsigned DEF_WRITE_BURST_LEN = 8;
  localparam int unsigned DEF_READ_LATENCY    = 2;

endpackage

// File: rtl/mem_sp_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_sp_array #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata_c = mem_q[addr];

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: fixed-length read/write bursts against local storage.
// Optional request/beat checking is enabled with `define BURST_MEM_CHK_EN.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int unsigned DATA_ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_WORDS_DATA_MEM = DEF_NUM_WORDS,
  parameter int unsigned READ_BURST_LEN     = DEF_READ_BURST_LEN,
  parameter int unsigned WRITE_BURST_LEN    = DEF_WRITE_BURST_LEN,
  parameter int unsigned READ_LATENCY       = DEF_READ_LATENCY
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [DATA_ADDR_WIDTH-1:0] req_addr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_last,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       wr_last,
  output logic                       wr_done
`ifdef BURST_MEM_CHK_EN
  ,
  output logic                       err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS_DATA_MEM);
  localparam int unsigned RB_W  = $clog2(READ_BURST_LEN + 1);
  localparam int unsigned WB_W  = $clog2(WRITE_BURST_LEN + 1);
  localparam int unsigned LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  state_e state_q, state_d;

  logic [IDX_W-1:0]      idx_q;
  logic [RB_W-1:0]       rbeat_q;
  logic [WB_W-1:0]       wbeat_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  req_ready_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_ready_q;
  logic                  wr_done_q;

  logic [DATA_WIDTH-1:0] mem_rdata_c;
  logic                  accept_c;
  logic                  rd_take_c;
  logic                  rd_load_c;
  logic                  wr_beat_c;
  logic                  wr_final_c;
  logic                  mem_we_c;
  logic                  rd_bad_c;

  assign accept_c   = req_valid && req_ready_q;
  assign rd_take_c  = (state_q == RDATA) && rd_valid_q && rd_ready;
  // Output slot is refilled whenever it is empty or being drained, until all beats are issued
  assign rd_load_c  = (state_q == RDATA) && (!rd_valid_q || rd_ready) &&
                      (rbeat_q != RB_W'(READ_BURST_LEN));
  assign wr_beat_c  = (state_q == WDATA) && wr_valid && wr_ready_q;
  assign wr_final_c = wr_beat_c && (wbeat_q == WB_W'(WRITE_BURST_LEN - 1));

  mem_sp_array #(
    .WIDTH  (DATA_WIDTH),
    .DEPTH  (NUM_WORDS_DATA_MEM),
    .ADDR_W (IDX_W)
  ) u_mem (
    .clk     (sys_clk),
    .we      (mem_we_c),
    .addr    (idx_q),
    .wdata   (wr_data),
    .rdata_c (mem_rdata_c)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_write) begin
            state_d = WDATA;
          end else if (rd_bad_c) begin
            state_d = IDLE;
          end else if (READ_LATENCY == 0) begin
            state_d = RDATA;
          end else begin
            state_d = RLAT;
          end
        end
      end
      RLAT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (rd_take_c && rd_last_q) begin
          state_d = IDLE;
        end
      end
      WDATA: begin
        if (wr_final_c) begin
          state_d = WRESP;
        end
      end
      WRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs, counters, and the read output slot
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q       <= '0;
      rbeat_q     <= '0;
      wbeat_q     <= '0;
      lat_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      req_ready_q <= (state_d == IDLE);
      wr_ready_q  <= (state_d == WDATA);
      wr_done_q   <= (state_d == WRESP);

      if (accept_c) begin
        idx_q   <= req_addr[WORD_OFFSET_BITS +: IDX_W];
        rbeat_q <= '0;
        wbeat_q <= '0;
        lat_q   <= '0;
      end

      if (state_q == RLAT) begin
        lat_q <= lat_q + LAT_W'(1);
      end

      if (wr_beat_c) begin
        idx_q   <= idx_q + IDX_W'(1);
        wbeat_q <= wbeat_q + WB_W'(1);
      end

      if (rd_load_c) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= mem_rdata_c;
        rd_last_q  <= (rbeat_q == RB_W'(READ_BURST_LEN - 1));
        idx_q      <= idx_q + IDX_W'(1);
        rbeat_q    <= rbeat_q + RB_W'(1);
      end else if (rd_take_c) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
        rd_last_q  <= 1'b0;
      end
    end
  end

`ifdef BURST_MEM_CHK_EN
  logic wr_discard_q;
  logic last_err_q;
  logic err_q;
  logic wr_bad_c;
  logic last_bad_c;

  assign rd_bad_c   = (req_addr % DATA_ADDR_WIDTH'(READ_BURST_LEN * 4)) != '0;
  assign wr_bad_c   = (req_addr % DATA_ADDR_WIDTH'(WRITE_BURST_LEN * 4)) != '0;
  assign last_bad_c = wr_beat_c && (wr_last != (wbeat_q == WB_W'(WRITE_BURST_LEN - 1)));
  assign mem_we_c   = wr_beat_c && !wr_discard_q;

  // Alignment and wr_last tracking; err aligns with wr_done for writes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_discard_q <= 1'b0;
      last_err_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= (accept_c && !req_write && rd_bad_c) ||
               (wr_final_c && (wr_discard_q || last_err_q || last_bad_c));
      if (accept_c) begin
        wr_discard_q <= req_write && wr_bad_c;
        last_err_q   <= 1'b0;
      end else if (last_bad_c) begin
        last_err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_inputs_c;

  assign rd_bad_c        = 1'b0;
  assign mem_we_c        = wr_beat_c;
  assign unused_inputs_c = ^{wr_last, req_addr};
`endif

  assign req_ready = req_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign wr_ready  = wr_ready_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder against a word-array model.
module tb_burst_mem_responder;

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 32;
  localparam int unsigned NW       = 128;
  localparam int unsigned RBL      = 8;
  localparam int unsigned WBL      = 8;
  localparam int          FIRST_RD = 3;   // cycles from accept edge to first rd_valid at latency 2
`ifdef BURST_MEM_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_done;
`ifdef BURST_MEM_CHK_EN
  logic          err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_mem [NW];
  logic [DW-1:0] wbuf [WBL];

  always #5 sys_clk = ~sys_clk;

  burst_mem_responder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_done   (wr_done)
`ifdef BURST_MEM_CHK_EN
    ,
    .err       (err)
`endif
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic bit misaligned(input logic [AW-1:0] addr, input int len);
    return CHK_EN && ((addr % AW'(len * 4)) != 0);
  endfunction

  function automatic int word_of(input logic [AW-1:0] addr);
    return int'((addr >> 2) % NW);
  endfunction

  // Present a request and return after its accept edge
  task automatic issue_req(input bit wr, input logic [AW-1:0] addr, output bit ok);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    for (int t = 0; t < 50 && !req_ready; t++) tick();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_accept: req_ready=%b required 1 within 50 cycles", req_ready);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int last_at, input int abort_after,
                             input bit gaps, input bit hold_rd, input logic [AW-1:0] rd_addr);
    int beat, idx, t;
    bit ok, bad, hs, exp_err;
    bad = misaligned(addr, WBL);
    exp_err = bad || (last_at != int'(WBL) - 1);
    idx = word_of(addr);
    issue_req(1'b1, addr, ok);
    if (!ok) return;
    if (hold_rd) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = rd_addr;
    end
    beat = 0;
    t = 0;
    while (beat < int'(WBL) && t < 200) begin
      if (abort_after >= 0 && beat == abort_after) begin
        wr_valid  = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL wr_abort_ready: wr_ready=%b required 0", wr_ready); end
        tick();
        sys_rst_n = 1'b1;
        tick();
        n_tests++;
        if (wr_done !== 1'b0) begin n_fail++; $display("FAIL wr_abort_done: wr_done=%b required 0", wr_done); end
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_abort_idle: req_ready=%b required 1", req_ready); end
        return;
      end
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = wbuf[beat];
      wr_last  = (beat == last_at);
      rd_ready = 1'($urandom_range(0, 1));
      n_tests++;
      if (wr_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_early: beat %0d wr_done=%b required 0", beat, wr_done); end
      if (hold_rd) begin
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL req_in_wdata: req_ready=%b required 0", req_ready); end
      end
      hs = wr_valid && wr_ready;
      tick();
      t++;
      if (hs) begin
        if (!bad) model_mem[(idx + beat) % NW] = wbuf[beat];
        beat++;
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_ready = 1'b0;
    n_tests++;
    if (beat != int'(WBL)) begin n_fail++; $display("FAIL wr_beats: %0d beats accepted, required %0d", beat, WBL); end
    n_tests++;
    if (wr_done !== 1'b1) begin n_fail++; $display("FAIL wr_done_pulse: wr_done=%b required 1", wr_done); end
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wresp_ready: req_ready=%b required 0", req_ready); end
`ifdef BURST_MEM_CHK_EN
    n_tests++;
    if (err !== exp_err) begin n_fail++; $display("FAIL wr_err: err=%b required %b", err, exp_err); end
`endif
    tick();
    n_tests++;
    if (wr_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_width: wr_done=%b required 0", wr_done); end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_return_idle: req_ready=%b required 1", req_ready); end
`ifdef BURST_MEM_CHK_EN
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err_width: err=%b required 0", err); end
`endif
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready plus stray write beats
  task automatic read_burst(input logic [AW-1:0] addr, input int mode, input int abort_after);
    int beat, idx, t, lat, cyc;
    bit ok, bad, hs;
    logic [DW-1:0] exp;
    bad = misaligned(addr, RBL);
    idx = word_of(addr);
    issue_req(1'b0, addr, ok);
    req_write = 1'b0;
    if (!ok) return;
    if (bad) begin
`ifdef BURST_MEM_CHK_EN
      n_tests++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL rd_err: err=%b required 1", err); end
`endif
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_bad_valid: rd_valid=%b required 0", rd_valid); end
        tick();
      end
`ifdef BURST_MEM_CHK_EN
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err_width: err=%b required 0", err); end
`endif
      n_tests++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_bad_idle: req_ready=%b required 1", req_ready); end
      return;
    end
    lat = 0;
    while (!rd_valid && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != FIRST_RD) begin n_fail++; $display("FAIL rd_latency: first beat after %0d cycles, required %0d", lat, FIRST_RD); end
    beat = 0;
    t = 0;
    cyc = 0;
    while (beat < int'(RBL) && t < 200) begin
      if (abort_after >= 0 && beat == abort_after) begin
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_abort_valid: rd_valid=%b required 0", rd_valid); end
        n_tests++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL rd_abort_data: rd_data=%h required 0", rd_data); end
        rd_ready = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_abort_idle: req_ready=%b required 1", req_ready); end
        return;
      end
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: begin
          rd_ready = 1'($urandom_range(0, 1));
          wr_valid = 1'($urandom_range(0, 1));
          wr_data  = DW'($urandom);
        end
      endcase
      exp = model_mem[(idx + beat) % NW];
      n_tests++;
      if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: beat %0d rd_valid=%b required 1", beat, rd_valid); end
      n_tests++;
      if (rd_data !== exp) begin n_fail++; $display("FAIL rd_data: beat %0d rd_data=%h required %h", beat, rd_data, exp); end
      n_tests++;
      if (rd_last !== (beat == int'(RBL) - 1)) begin
        n_fail++;
        $display("FAIL rd_last: beat %0d rd_last=%b required %b", beat, rd_last, beat == int'(RBL) - 1);
      end
      hs = rd_valid && rd_ready;
      tick();
      t++;
      cyc++;
      if (hs) beat++;
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    n_tests++;
    if (beat != int'(RBL)) begin n_fail++; $display("FAIL rd_beats: %0d beats, required %0d", beat, RBL); end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rd_end: valid=%b last=%b data=%h required 0,0,0", rd_valid, rd_last, rd_data);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_return_idle: req_ready=%b required 1", req_ready); end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: %b required 1", req_ready); end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd: valid=%b last=%b required 0,0", rd_valid, rd_last); end
    n_tests++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: %h required 0", rd_data); end
    n_tests++;
    if (wr_ready !== 1'b0 || wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr: ready=%b done=%b required 0,0", wr_ready, wr_done); end
`ifdef BURST_MEM_CHK_EN
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: %b required 0", err); end
`endif
  endtask

  task automatic test_fill();
    for (int b = 0; b < int'(NW / WBL); b++) begin
      for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
      write_burst(AW'(b * int'(WBL) * 4), int'(WBL) - 1, -1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_directed_write_read();
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'((i + 1) * 'h11);
    write_burst(AW'('h20), int'(WBL) - 1, -1, 1'b1, 1'b0, '0);
    read_burst(AW'('h20), 0, -1);
  endtask

  task automatic test_backpressure();
    read_burst(AW'('h20), 1, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('h1F0), int'(WBL) - 1, -1, 1'b1, 1'b0, '0);
    read_burst(AW'('h1F0), 2, -1);
    read_burst(AW'('h000), 0, -1);
  endtask

  task automatic test_reset_mid_burst();
    read_burst(AW'('h40), 0, 3);
    read_burst(AW'('h40), 0, -1);
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('h60), int'(WBL) - 1, 3, 1'b0, 1'b0, '0);
    read_burst(AW'('h60), 0, -1);
  endtask

  task automatic test_req_during_write();
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('h80), int'(WBL) - 1, -1, 1'b1, 1'b1, AW'('h80));
    read_burst(AW'('h80), 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('hA0), int'(WBL) - 1, -1, 1'b0, 1'b0, '0);
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('hC0), int'(WBL) - 1, -1, 1'b0, 1'b0, '0);
    read_burst(AW'('hA0), 0, -1);
    read_burst(AW'('hC0), 0, -1);
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    for (int n = 0; n < 24; n++) begin
      addr = AW'($urandom_range(0, NW - 1) * 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
        write_burst(addr, CHK_EN ? int'(WBL) - 1 : int'($urandom_range(0, WBL)), -1, 1'b1, 1'b0, '0);
      end else begin
        read_burst(addr, 2, -1);
      end
    end
  endtask

`ifdef BURST_MEM_CHK_EN
  task automatic test_chk();
    read_burst(AW'('h04), 0, -1);
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('h100), 5, -1, 1'b0, 1'b0, '0);
    read_burst(AW'('h100), 0, -1);
    for (int i = 0; i < int'(WBL); i++) wbuf[i] = DW'($urandom);
    write_burst(AW'('h124), int'(WBL) - 1, -1, 1'b0, 1'b0, '0);
    read_burst(AW'('h120), 0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_directed_write_read();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_req_during_write();
    test_back_to_back();
`ifdef BURST_MEM_CHK_EN
    test_chk();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
